// File: rtl/multibuf_write_router_if.sv
// rtl/multibuf_write_router_if.sv - write buses into the router and per-bank RAM write ports out of it
interface multibuf_write_router_if #(
    parameter int FFT_N     = 10,
    parameter int FFT_DW    = 16,
    parameter int NUM_BANKS = 3
);
    logic                              wact_fft;
    logic [FFT_N-2:0]                  wa_fft;
    logic [2*FFT_DW-1:0]               wdw_fft;
    logic                              wact_istream;
    logic [FFT_N-2:0]                  wa_istream;
    logic [2*FFT_DW-1:0]               wdw_istream;
    logic [NUM_BANKS-1:0]              wact_ram;
    logic [NUM_BANKS*(FFT_N-1)-1:0]    wa_ram;
    logic [NUM_BANKS*2*FFT_DW-1:0]     wdw_ram;

    modport master (
        output wact_fft, wa_fft, wdw_fft, wact_istream, wa_istream, wdw_istream,
        input  wact_ram, wa_ram, wdw_ram
    );

    modport slave (
        input  wact_fft, wa_fft, wdw_fft, wact_istream, wa_istream, wdw_istream,
        output wact_ram, wa_ram, wdw_ram
    );
endinterface

// File: rtl/multibuf_write_router.sv
// rtl/multibuf_write_router.sv - rotating input/FFT/DMA bank roles with registered per-bank write routing
module multibuf_write_router #(
    parameter int FFT_N     = 10,
    parameter int FFT_DW    = 16,
    parameter int NUM_BANKS = 3,
    localparam int BW       = (NUM_BANKS > 2) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  istream_done,
    input  logic                  fft_done,
    input  logic                  dma_done,
    input  logic                  overrun_clr,
    multibuf_write_router_if.slave bus,
    output logic [BW-1:0]         in_bank,
    output logic [BW-1:0]         fft_bank,
    output logic [BW-1:0]         dma_bank,
    output logic                  fft_start,
    output logic                  dma_start,
    output logic                  overrun
);
    localparam int AW = FFT_N - 1;
    localparam int DW = 2 * FFT_DW;
    localparam logic [BW:0] NB = (BW+1)'(NUM_BANKS);

    typedef enum logic [1:0] {IDLE, RUN, ROTATE} state_t;
    state_t state;

    logic fft_vld, dma_vld, in_dn, fft_dn, dma_dn;

    logic [BW:0]   fft_sum, dma_sum, fft_mod, dma_mod;
    logic [BW-1:0] prev_bank;

    assign fft_sum   = {1'b0, in_bank} + (BW+1)'(1);
    assign dma_sum   = {1'b0, in_bank} + (BW+1)'(2);
    assign fft_mod   = (fft_sum >= NB) ? fft_sum - NB : fft_sum;
    assign dma_mod   = (dma_sum >= NB) ? dma_sum - NB : dma_sum;
    assign fft_bank  = fft_mod[BW-1:0];
    assign dma_bank  = dma_mod[BW-1:0];
    assign prev_bank = (in_bank == '0) ? BW'(NUM_BANKS - 1) : in_bank - 1'b1;

    logic rot_cond, is_ok, ov_set;

    // A role that holds no valid data never blocks rotation.
    assign rot_cond = (in_dn | istream_done) &
                      (fft_dn | fft_done | ~fft_vld) &
                      (dma_dn | dma_done | ~dma_vld);
    assign is_ok    = (state != IDLE) & ~in_dn;
    assign ov_set   = (bus.wact_istream & ~is_ok) | ((state == RUN) & istream_done & in_dn);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_bank   <= '0;
            fft_vld   <= 1'b0;
            dma_vld   <= 1'b0;
            in_dn     <= 1'b0;
            fft_dn    <= 1'b0;
            dma_dn    <= 1'b0;
            fft_start <= 1'b0;
            dma_start <= 1'b0;
        end else begin
            fft_start <= 1'b0;
            dma_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) state <= RUN;
                end
                RUN: begin
                    in_dn  <= in_dn | istream_done;
                    fft_dn <= fft_dn | fft_done;
                    dma_dn <= dma_dn | dma_done;
                    if (rot_cond) state <= ROTATE;
                end
                ROTATE: begin
                    // Filled input bank becomes the FFT bank, FFT bank moves on to DMA.
                    in_bank   <= prev_bank;
                    fft_vld   <= 1'b1;
                    dma_vld   <= fft_vld;
                    in_dn     <= 1'b0;
                    fft_dn    <= 1'b0;
                    dma_dn    <= 1'b0;
                    fft_start <= 1'b1;
                    dma_start <= fft_vld;
                    state     <= RUN;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           overrun <= 1'b0;
        else if (ov_set)      overrun <= 1'b1;
        else if (overrun_clr) overrun <= 1'b0;
    end

    logic [NUM_BANKS-1:0]    wact_d, wact_q;
    logic [NUM_BANKS*AW-1:0] wa_d, wa_q;
    logic [NUM_BANKS*DW-1:0] wdw_d, wdw_q;

    always_comb begin
        wact_d = '0;
        wa_d   = '0;
        wdw_d  = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (in_bank == BW'(k)) begin
                wact_d[k]          = bus.wact_istream & is_ok;
                wa_d[k*AW +: AW]   = bus.wa_istream;
                wdw_d[k*DW +: DW]  = bus.wdw_istream;
            end else if (fft_bank == BW'(k)) begin
                wact_d[k]          = bus.wact_fft & fft_vld;
                wa_d[k*AW +: AW]   = bus.wa_fft;
                wdw_d[k*DW +: DW]  = bus.wdw_fft;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wact_q <= '0;
            wa_q   <= '0;
            wdw_q  <= '0;
        end else begin
            wact_q <= wact_d;
            wa_q   <= wa_d;
            wdw_q  <= wdw_d;
        end
    end

    assign bus.wact_ram = wact_q;
    assign bus.wa_ram   = wa_q;
    assign bus.wdw_ram  = wdw_q;
endmodule

// File: tb/tb_multibuf_write_router.sv
// tb/tb_multibuf_write_router.sv - bench driving 3-bank and 5-bank routers side by side against a reference model
module tb_multibuf_write_router;
    localparam int FN = 10;
    localparam int DWH = 16;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int NB [2] = '{3, 5};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic enable = 0, istream_done = 0, fft_done = 0, dma_done = 0, overrun_clr = 0;
    logic wact_fft = 0, wact_istream = 0;
    logic [AW-1:0] wa_fft = '0, wa_istream = '0;
    logic [DW-1:0] wdw_fft = '0, wdw_istream = '0;

    multibuf_write_router_if #(.FFT_N(FN), .FFT_DW(DWH), .NUM_BANKS(3)) bus3 ();
    multibuf_write_router_if #(.FFT_N(FN), .FFT_DW(DWH), .NUM_BANKS(5)) bus5 ();

    assign bus3.wact_fft = wact_fft;         assign bus5.wact_fft = wact_fft;
    assign bus3.wa_fft = wa_fft;             assign bus5.wa_fft = wa_fft;
    assign bus3.wdw_fft = wdw_fft;           assign bus5.wdw_fft = wdw_fft;
    assign bus3.wact_istream = wact_istream; assign bus5.wact_istream = wact_istream;
    assign bus3.wa_istream = wa_istream;     assign bus5.wa_istream = wa_istream;
    assign bus3.wdw_istream = wdw_istream;   assign bus5.wdw_istream = wdw_istream;

    logic [1:0] in3, fb3, db3;
    logic [2:0] in5, fb5, db5;
    logic fs3, ds3, ov3, fs5, ds5, ov5;

    multibuf_write_router #(.FFT_N(FN), .FFT_DW(DWH), .NUM_BANKS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .istream_done(istream_done),
        .fft_done(fft_done), .dma_done(dma_done), .overrun_clr(overrun_clr), .bus(bus3),
        .in_bank(in3), .fft_bank(fb3), .dma_bank(db3),
        .fft_start(fs3), .dma_start(ds3), .overrun(ov3)
    );

    multibuf_write_router #(.FFT_N(FN), .FFT_DW(DWH), .NUM_BANKS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .istream_done(istream_done),
        .fft_done(fft_done), .dma_done(dma_done), .overrun_clr(overrun_clr), .bus(bus5),
        .in_bank(in5), .fft_bank(fb5), .dma_bank(db5),
        .fft_start(fs5), .dma_start(ds5), .overrun(ov5)
    );

    logic [4:0]   a_wact [2];
    logic [44:0]  a_wa   [2];
    logic [159:0] a_wdw  [2];
    logic [2:0]   a_in [2], a_fb [2], a_db [2];
    logic         a_fs [2], a_ds [2], a_ov [2];

    assign a_wact[0] = {2'b0, bus3.wact_ram};  assign a_wact[1] = bus5.wact_ram;
    assign a_wa[0]   = {18'b0, bus3.wa_ram};   assign a_wa[1]   = bus5.wa_ram;
    assign a_wdw[0]  = {64'b0, bus3.wdw_ram};  assign a_wdw[1]  = bus5.wdw_ram;
    assign a_in[0] = {1'b0, in3}; assign a_fb[0] = {1'b0, fb3}; assign a_db[0] = {1'b0, db3};
    assign a_in[1] = in5;         assign a_fb[1] = fb5;         assign a_db[1] = db5;
    assign a_fs[0] = fs3; assign a_ds[0] = ds3; assign a_ov[0] = ov3;
    assign a_fs[1] = fs5; assign a_ds[1] = ds5; assign a_ov[1] = ov5;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 running, 2 rotating.
    int m_mode [2], m_in [2];
    bit m_fv [2], m_dv [2], m_idn [2], m_fdn [2], m_ddn [2], m_ov [2], m_fs [2], m_ds [2];
    logic [4:0]   e_wact [2];
    logic [44:0]  e_wa   [2];
    logic [159:0] e_wdw  [2];

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = 0; m_in[c] = 0;
            m_fv[c] = 0; m_dv[c] = 0; m_idn[c] = 0; m_fdn[c] = 0; m_ddn[c] = 0;
            m_ov[c] = 0; m_fs[c] = 0; m_ds[c] = 0;
            e_wact[c] = '0; e_wa[c] = '0; e_wdw[c] = '0;
        end
    endtask

    task automatic model_step();
        int n, bi, bf;
        bit set, rot;
        for (int c = 0; c < 2; c++) begin
            n = NB[c]; bi = m_in[c]; bf = (bi + 1) % n;
            e_wact[c] = '0; e_wa[c] = '0; e_wdw[c] = '0;
            e_wact[c][bi] = wact_istream && (m_mode[c] != 0) && !m_idn[c];
            e_wa[c][bi*AW +: AW] = wa_istream;
            e_wdw[c][bi*DW +: DW] = wdw_istream;
            e_wact[c][bf] = wact_fft && m_fv[c];
            e_wa[c][bf*AW +: AW] = wa_fft;
            e_wdw[c][bf*DW +: DW] = wdw_fft;
            set = (wact_istream && (m_mode[c] == 0 || m_idn[c])) ||
                  (m_mode[c] == 1 && istream_done && m_idn[c]);
            if (set) m_ov[c] = 1;
            else if (overrun_clr) m_ov[c] = 0;
            m_fs[c] = 0; m_ds[c] = 0;
            if (m_mode[c] == 0) begin
                if (enable) m_mode[c] = 1;
            end else if (m_mode[c] == 1) begin
                rot = (m_idn[c] || istream_done) && (m_fdn[c] || fft_done || !m_fv[c]) &&
                      (m_ddn[c] || dma_done || !m_dv[c]);
                m_idn[c] |= istream_done; m_fdn[c] |= fft_done; m_ddn[c] |= dma_done;
                if (rot) m_mode[c] = 2;
            end else begin
                m_in[c] = (m_in[c] + n - 1) % n;
                m_fs[c] = 1; m_ds[c] = m_fv[c];
                m_dv[c] = m_fv[c]; m_fv[c] = 1;
                m_idn[c] = 0; m_fdn[c] = 0; m_ddn[c] = 0;
                m_mode[c] = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_inputs();
        enable = 0; istream_done = 0; fft_done = 0; dma_done = 0; overrun_clr = 0;
        wact_fft = 0; wact_istream = 0; wa_fft = '0; wa_istream = '0; wdw_fft = '0; wdw_istream = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        #2;
        model_reset();
        rst_n = 1;
    endtask

    task automatic pulse_rotate_istream();
        istream_done = 1; tick(); istream_done = 0; tick();
    endtask

    task automatic test_reset();
        enable = 1; tick();
        pulse_rotate_istream();
        wact_istream = 1; wa_istream = 9'h155; wdw_istream = $urandom; tick();
        wact_istream = 0;
        rst_n = 0;
        #1;
        for (int c = 0; c < 2; c++) begin
            checks++; if (a_wact[c] !== 5'd0) begin errors++; $display("FAIL reset_wact c%0d got %0h want 0", c, a_wact[c]); end
            checks++; if (a_wa[c] !== 45'd0) begin errors++; $display("FAIL reset_wa c%0d got %0h want 0", c, a_wa[c]); end
            checks++; if (a_wdw[c] !== 160'd0) begin errors++; $display("FAIL reset_wdw c%0d got %0h want 0", c, a_wdw[c]); end
            checks++; if ({a_in[c], a_fb[c], a_db[c]} !== {3'd0, 3'd1, 3'd2}) begin errors++; $display("FAIL reset_banks c%0d got %0d/%0d/%0d want 0/1/2", c, a_in[c], a_fb[c], a_db[c]); end
            checks++; if ({a_fs[c], a_ds[c], a_ov[c]} !== 3'b000) begin errors++; $display("FAIL reset_flags c%0d got %b want 000", c, {a_fs[c], a_ds[c], a_ov[c]}); end
        end
        clear_inputs();
        #1;
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_first_rotation();
        do_reset();
        enable = 1; tick();
        pulse_rotate_istream();
        checks++; if ({a_in[0], a_fb[0], a_db[0]} !== {3'd2, 3'd0, 3'd1}) begin errors++; $display("FAIL first_rot_banks c0 got %0d/%0d/%0d want 2/0/1", a_in[0], a_fb[0], a_db[0]); end
        checks++; if ({a_in[1], a_fb[1], a_db[1]} !== {3'd4, 3'd0, 3'd1}) begin errors++; $display("FAIL first_rot_banks c1 got %0d/%0d/%0d want 4/0/1", a_in[1], a_fb[1], a_db[1]); end
        for (int c = 0; c < 2; c++) begin
            checks++; if ({a_fs[c], a_ds[c]} !== 2'b10) begin errors++; $display("FAIL first_rot_start c%0d got %b want 10", c, {a_fs[c], a_ds[c]}); end
        end
        tick();
        for (int c = 0; c < 2; c++) begin
            checks++; if ({a_fs[c], a_ds[c]} !== 2'b00) begin errors++; $display("FAIL start_single_cycle c%0d got %b want 00", c, {a_fs[c], a_ds[c]}); end
        end
    endtask

    task automatic test_fft_wait();
        istream_done = 1; tick(); istream_done = 0;
        repeat (5) tick();
        checks++; if ({a_in[0], a_in[1]} !== {3'd2, 3'd4}) begin errors++; $display("FAIL wait_no_rot got %0d/%0d want 2/4", a_in[0], a_in[1]); end
        fft_done = 1; tick(); fft_done = 0; tick();
        checks++; if ({a_in[0], a_in[1]} !== {3'd1, 3'd3}) begin errors++; $display("FAIL wait_rot_bank got %0d/%0d want 1/3", a_in[0], a_in[1]); end
        for (int c = 0; c < 2; c++) begin
            checks++; if ({a_fs[c], a_ds[c]} !== 2'b11) begin errors++; $display("FAIL wait_rot_start c%0d got %b want 11", c, {a_fs[c], a_ds[c]}); end
        end
    endtask

    task automatic test_all_done();
        do_reset();
        enable = 1; tick();
        for (int r = 0; r < 3; r++) begin
            istream_done = 1; fft_done = 1; dma_done = 1; tick();
            istream_done = 0; fft_done = 0; dma_done = 0; tick();
            for (int c = 0; c < 2; c++) begin
                checks++; if ({a_fs[c], a_ds[c]} !== {1'b1, r > 0}) begin errors++; $display("FAIL all_done_start r%0d c%0d got %b want %b", r, c, {a_fs[c], a_ds[c]}, {1'b1, r > 0}); end
            end
        end
        checks++; if ({a_in[0], a_in[1]} !== {3'd0, 3'd2}) begin errors++; $display("FAIL all_done_bank got %0d/%0d want 0/2", a_in[0], a_in[1]); end
    endtask

    task automatic test_write_route();
        logic [8:0]  rwa;
        logic [31:0] rwd;
        do_reset();
        enable = 1; tick();
        pulse_rotate_istream();
        wact_istream = 1; wa_istream = 9'h1F; wdw_istream = 32'hA5A5_5A5A; tick();
        wact_istream = 0; wa_istream = '0; wdw_istream = '0;
        checks++; if ({a_wact[0], a_wa[0], a_wdw[0]} !== {5'b00100, 45'h1F << 18, 160'hA5A5_5A5A << 64}) begin errors++; $display("FAIL route_is c0 got %b %0h %0h", a_wact[0], a_wa[0], a_wdw[0]); end
        checks++; if ({a_wact[1], a_wa[1], a_wdw[1]} !== {5'b10000, 45'h1F << 36, 160'hA5A5_5A5A << 128}) begin errors++; $display("FAIL route_is c1 got %b %0h %0h", a_wact[1], a_wa[1], a_wdw[1]); end
        rwa = 9'($urandom); rwd = $urandom;
        wact_fft = 1; wa_fft = rwa; wdw_fft = rwd; tick();
        wact_fft = 0; wa_fft = '0; wdw_fft = '0;
        for (int c = 0; c < 2; c++) begin
            checks++; if ({a_wact[c], a_wa[c], a_wdw[c]} !== {5'b00001, 45'(rwa), 160'(rwd)}) begin errors++; $display("FAIL route_fft c%0d got %b %0h %0h want 00001 %0h %0h", c, a_wact[c], a_wa[c], a_wdw[c], rwa, rwd); end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        wact_istream = 1; wa_istream = 9'($urandom); wdw_istream = $urandom;
        wact_fft = 1; wa_fft = 9'($urandom); wdw_fft = $urandom; tick();
        clear_inputs();
        for (int c = 0; c < 2; c++) begin
            checks++; if ({a_wact[c], a_ov[c]} !== {5'b0, 1'b1}) begin errors++; $display("FAIL idle_drop c%0d got %b/%b want 00000/1", c, a_wact[c], a_ov[c]); end
        end
        checks++; if ({a_wa[1][44:27], a_wdw[1][159:96]} !== 82'd0) begin errors++; $display("FAIL idle_banks_34 got %0h %0h want 0", a_wa[1][44:27], a_wdw[1][159:96]); end
        overrun_clr = 1; tick(); overrun_clr = 0;
        checks++; if ({a_ov[0], a_ov[1]} !== 2'b00) begin errors++; $display("FAIL ov_clear got %b want 00", {a_ov[0], a_ov[1]}); end
        enable = 1; tick();
        wact_fft = 1; tick(); wact_fft = 0;
        checks++; if ({a_wact[0], a_wact[1], a_ov[0], a_ov[1]} !== 12'd0) begin errors++; $display("FAIL fft_drop got %b %b %b%b want 0", a_wact[0], a_wact[1], a_ov[0], a_ov[1]); end
        pulse_rotate_istream();
        istream_done = 1; tick(); istream_done = 0;
        wact_istream = 1; tick(); wact_istream = 0;
        checks++; if ({a_wact[0], a_wact[1], a_ov[0], a_ov[1]} !== {10'd0, 2'b11}) begin errors++; $display("FAIL done_drop got %b %b %b%b want 0 0 11", a_wact[0], a_wact[1], a_ov[0], a_ov[1]); end
        overrun_clr = 1; wact_istream = 1; tick(); wact_istream = 0;
        checks++; if ({a_ov[0], a_ov[1]} !== 2'b11) begin errors++; $display("FAIL set_wins got %b want 11", {a_ov[0], a_ov[1]}); end
        tick(); overrun_clr = 0;
        checks++; if ({a_ov[0], a_ov[1]} !== 2'b00) begin errors++; $display("FAIL ov_clear2 got %b want 00", {a_ov[0], a_ov[1]}); end
        istream_done = 1; tick(); istream_done = 0;
        checks++; if ({a_ov[0], a_ov[1]} !== 2'b11) begin errors++; $display("FAIL double_done got %b want 11", {a_ov[0], a_ov[1]}); end
    endtask

    task automatic test_random();
        int eb;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            enable = ($urandom % 4) != 0;
            istream_done = ($urandom % 6) == 0;
            fft_done = ($urandom % 5) == 0;
            dma_done = ($urandom % 5) == 0;
            overrun_clr = ($urandom % 16) == 0;
            wact_istream = $urandom % 2; wa_istream = 9'($urandom); wdw_istream = $urandom;
            wact_fft = $urandom % 2; wa_fft = 9'($urandom); wdw_fft = $urandom;
            tick();
            for (int c = 0; c < 2; c++) begin
                checks++; if (a_wact[c] !== e_wact[c]) begin errors++; $display("FAIL rnd_wact i%0d c%0d got %b want %b", i, c, a_wact[c], e_wact[c]); end
                checks++; if (a_wa[c] !== e_wa[c]) begin errors++; $display("FAIL rnd_wa i%0d c%0d got %0h want %0h", i, c, a_wa[c], e_wa[c]); end
                checks++; if (a_wdw[c] !== e_wdw[c]) begin errors++; $display("FAIL rnd_wdw i%0d c%0d got %0h want %0h", i, c, a_wdw[c], e_wdw[c]); end
                checks++; if (a_in[c] !== 3'(m_in[c])) begin errors++; $display("FAIL rnd_in i%0d c%0d got %0d want %0d", i, c, a_in[c], m_in[c]); end
                eb = (m_in[c] + 1) % NB[c];
                checks++; if (a_fb[c] !== 3'(eb)) begin errors++; $display("FAIL rnd_fb i%0d c%0d got %0d want %0d", i, c, a_fb[c], eb); end
                eb = (m_in[c] + 2) % NB[c];
                checks++; if (a_db[c] !== 3'(eb)) begin errors++; $display("FAIL rnd_db i%0d c%0d got %0d want %0d", i, c, a_db[c], eb); end
                checks++; if ({a_fs[c], a_ds[c], a_ov[c]} !== {m_fs[c], m_ds[c], m_ov[c]}) begin errors++; $display("FAIL rnd_flags i%0d c%0d got %b want %b", i, c, {a_fs[c], a_ds[c], a_ov[c]}, {m_fs[c], m_ds[c], m_ov[c]}); end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        test_reset();
        test_first_rotation();
        test_fft_wait();
        test_all_done();
        test_write_route();
        test_overrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
